eth_rxstatem_gen: RTL and testbench
===================================

ETH_RXSTATEM_GEN -- requirements
Module: eth_rxstatem_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 4, receive data width (4 = MII nibble, 8 = GMII byte); other values are illegal.
REQ-002 SHALL have parameter CNT_W, default 16, width of the byte counter.
REQ-003 SHALL have parameter MAX_FRAME, default 1536, maximum data bytes accepted per frame.
REQ-004 SHALL have parameter MIN_IFG, default 24, minimum idle MRxClk cycles required between frames.
REQ-005 SHALL have port MRxClk  in  1  receive clock, all state updates on its rising edge.
REQ-006 SHALL have port Reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports MRxDV in 1 data valid; MRxD in DATA_W receive data; MRxErr in 1 PHY error; Transmitting in 1 local transmit active.
REQ-008 SHALL have ports StateIdle, StatePreamble, StateSFD, StateDrop, each out 1, state indicators.
REQ-009 SHALL have port StateData out 2: {Data1, Data0} phase; bit 1 is constant 0 when DATA_W=8.
REQ-010 SHALL have ports ByteCnt out CNT_W data bytes received; FrameDone out 1 end-of-frame pulse; Oversize, RxErrSeen, Dribble out 1 status flags valid with FrameDone.

Function
REQ-011 SHALL hold exactly one of IDLE, PREAMBLE, SFD, DATA0, DATA1, DROP at all times; the state indicators are one-hot and registered.
REQ-012 SHALL use PRE = 0x5 / 0x55 and SFD = 0xD / 0xD5 for DATA_W = 4 / 8.
REQ-013 SHALL give ~MRxDV top priority: any state other than IDLE goes to IDLE in the next cycle.
REQ-014 IDLE with MRxDV: Transmitting -> DROP; otherwise MRxD==PRE -> SFD, any other value -> PREAMBLE.
REQ-015 PREAMBLE with MRxDV: MRxD==PRE -> SFD; otherwise hold.
REQ-016 SFD with MRxDV: MRxD==SFD and IFG counter == MIN_IFG -> DATA0; MRxD==SFD and IFG counter < MIN_IFG -> DROP; otherwise hold.
REQ-017 DATA0 with MRxDV: ByteCnt == MAX_FRAME -> DROP with Oversize set; otherwise DATA1 (DATA_W=4) or stay in DATA0 (DATA_W=8).
REQ-018 DATA1 with MRxDV SHALL go to DATA0; DROP with MRxDV SHALL hold.
REQ-019 ByteCnt SHALL clear on SFD->DATA0, increment on each DATA1 cycle (DATA_W=4) or each DATA0 cycle (DATA_W=8), saturate at MAX_FRAME, and hold after frame end until the next SFD->DATA0.
REQ-020 IFG counter SHALL clear on any cycle with MRxDV=1, increment while MRxDV=0, and saturate at MIN_IFG.
REQ-021 FrameDone SHALL pulse for one cycle, in the cycle after a DATA0/DATA1 -> IDLE transition; DROP -> IDLE SHALL NOT pulse.
REQ-022 Dribble SHALL be set when DATA_W=4 and the frame leaves from DATA1 (odd nibble count); it is always 0 when DATA_W=8.
REQ-023 Oversize, RxErrSeen and Dribble SHALL clear on SFD->DATA0 and hold until the next such transition.

Reset
REQ-024 While Reset_n=0: StateDrop=1; StateIdle, StatePreamble, StateSFD, StateData all 0; ByteCnt=0; IFG counter=0; FrameDone and all flags 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame without a FrameDone pulse; after release the block leaves DROP only once MRxDV=0.

Configuration
REQ-026 With ETH_RXSTATEM_ERR_EN defined, MRxErr=1 in DATA0/DATA1 with MRxDV SHALL set RxErrSeen and go to DROP; without it, MRxErr SHALL be ignored and RxErrSeen SHALL be tied to 0.

Structure
REQ-027 Package eth_rx_pkg SHALL hold the state enum, PRE/SFD constants per DATA_W, and the status-flag struct.
REQ-028 The IFG saturating counter SHALL be a sub-module eth_rx_ifgcnt; all other logic stays in eth_rxstatem_gen.

Verification
REQ-029 DATA_W=4: 30 idle cycles, then 15x 0x5, 0xD, 128 nibbles, then MRxDV low -> DATA0/DATA1 alternate; FrameDone pulses once; ByteCnt=64; Dribble=0.
REQ-030 DATA_W=4: 10 idle cycles, then preamble and SFD -> DROP; no FrameDone; IDLE after MRxDV falls.
REQ-031 DATA_W=8, MAX_FRAME=64: 30 idle cycles, then 7x 0x55, 0xD5, 70 bytes -> DROP after ByteCnt=64; Oversize=1; no FrameDone.
REQ-032 DATA_W=4: frame of 129 data nibbles -> FrameDone with Dribble=1 and ByteCnt=64.
REQ-033 Transmitting=1 at MRxDV rise -> DROP; ERR_EN build with MRxErr pulsed mid-data -> DROP with RxErrSeen=1.
REQ-034 Reset_n pulsed low mid-DATA0 -> StateDrop=1 and ByteCnt=0 immediately; no FrameDone.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - receive state encoding, preamble/SFD constants and status flags
package eth_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA0    = 3'd3,
    ST_DATA1    = 3'd4,
    ST_DROP     = 3'd5
  } rx_state_e;

  typedef struct packed {
    logic oversize;
    logic rxErr;
    logic dribble;
  } rx_flags_t;

  localparam logic [7:0] PRE_NIBBLE = 8'h05;
  localparam logic [7:0] PRE_BYTE   = 8'h55;
  localparam logic [7:0] SFD_NIBBLE = 8'h0D;
  localparam logic [7:0] SFD_BYTE   = 8'hD5;

  // Preamble symbol for the given receive width (only the low DATA_W bits are compared)
  function automatic logic [7:0] preVal(input int dataW);
    return (dataW == 8) ? PRE_BYTE : PRE_NIBBLE;
  endfunction

  // Start-of-frame delimiter symbol for the given receive width
  function automatic logic [7:0] sfdVal(input int dataW);
    return (dataW == 8) ? SFD_BYTE : SFD_NIBBLE;
  endfunction

endpackage

// File: rtl/eth_rx_ifgcnt.sv
// rtl/eth_rx_ifgcnt.sv - saturating inter-frame-gap counter
module eth_rx_ifgcnt #(
  parameter int MAX_CNT = 24,
  parameter int CNT_W   = 5
) (
  input  logic             MRxClk,
  input  logic             Reset_n,
  input  logic             MRxDV,
  output logic [CNT_W-1:0] IfgCnt
);

  // Count idle cycles since carrier dropped; any valid cycle restarts the gap
  always_ff @(posedge MRxClk or negedge Reset_n) begin
    if (!Reset_n) begin
      IfgCnt <= '0;
    end else if (MRxDV) begin
      IfgCnt <= '0;
    end else if (IfgCnt != CNT_W'(MAX_CNT)) begin
      IfgCnt <= IfgCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/eth_rxstatem_gen.sv
// rtl/eth_rxstatem_gen.sv - MII/GMII receive state machine; ETH_RXSTATEM_ERR_EN enables PHY error drop
module eth_rxstatem_gen #(
  parameter int DATA_W    = 4,
  parameter int CNT_W     = 16,
  parameter int MAX_FRAME = 1536,
  parameter int MIN_IFG   = 24
) (
  input  logic              MRxClk,
  input  logic              Reset_n,
  input  logic              MRxDV,
  input  logic [DATA_W-1:0] MRxD,
  input  logic              MRxErr,
  input  logic              Transmitting,
  output logic              StateIdle,
  output logic              StatePreamble,
  output logic              StateSFD,
  output logic              StateDrop,
  output logic [1:0]        StateData,
  output logic [CNT_W-1:0]  ByteCnt,
  output logic              FrameDone,
  output logic              Oversize,
  output logic              RxErrSeen,
  output logic              Dribble
);
  import eth_rx_pkg::*;

  localparam int         IFG_W  = (MIN_IFG > 0) ? $clog2(MIN_IFG + 1) : 1;
  localparam logic [7:0] PRE8   = preVal(DATA_W);
  localparam logic [7:0] SFD8   = sfdVal(DATA_W);
  localparam bit         NIBBLE = (DATA_W == 4);

  rx_state_e          state;
  rx_state_e          nextState;
  rx_flags_t          flags;
  logic [IFG_W-1:0]   ifgCnt;
  logic               ifgOk;
  logic               isPre;
  logic               isSfd;
  logic               atMax;
  logic               inData;
  logic               errHit;
  logic               startData;
  logic               countCycle;

  eth_rx_ifgcnt #(
    .MAX_CNT(MIN_IFG),
    .CNT_W  (IFG_W)
  ) u_ifgcnt (
    .MRxClk (MRxClk),
    .Reset_n(Reset_n),
    .MRxDV  (MRxDV),
    .IfgCnt (ifgCnt)
  );

`ifdef ETH_RXSTATEM_ERR_EN
  assign errHit = MRxErr;
`else
  logic unusedErr;
  assign errHit    = 1'b0;
  assign unusedErr = MRxErr;
`endif

  assign isPre  = (MRxD == PRE8[DATA_W-1:0]);
  assign isSfd  = (MRxD == SFD8[DATA_W-1:0]);
  assign atMax  = (ByteCnt == CNT_W'(MAX_FRAME));
  assign inData = (state == ST_DATA0) || (state == ST_DATA1);

  // Next-state decode; loss of carrier always returns to idle
  always_comb begin
    nextState = state;
    if (!MRxDV) begin
      nextState = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     nextState = Transmitting ? ST_DROP : (isPre ? ST_SFD : ST_PREAMBLE);
        ST_PREAMBLE: if (isPre) nextState = ST_SFD;
        ST_SFD:      if (isSfd) nextState = ifgOk ? ST_DATA0 : ST_DROP;
        ST_DATA0: begin
          if (errHit || atMax) nextState = ST_DROP;
          else                 nextState = NIBBLE ? ST_DATA1 : ST_DATA0;
        end
        ST_DATA1:    nextState = errHit ? ST_DROP : ST_DATA0;
        ST_DROP:     nextState = ST_DROP;
        default:     nextState = ST_DROP;
      endcase
    end
  end

  assign startData  = (state == ST_SFD) && (nextState == ST_DATA0);
  assign countCycle = (nextState == ST_DATA0) && (state == (NIBBLE ? ST_DATA1 : ST_DATA0));

  // State register; reset parks in DROP so a frame in flight is discarded
  always_ff @(posedge MRxClk or negedge Reset_n) begin
    if (!Reset_n) state <= ST_DROP;
    else          state <= nextState;
  end

  // The gap counter clears as soon as carrier rises, so its verdict is captured on that cycle
  always_ff @(posedge MRxClk or negedge Reset_n) begin
    if (!Reset_n)                      ifgOk <= 1'b0;
    else if (state == ST_IDLE && MRxDV) ifgOk <= (ifgCnt == IFG_W'(MIN_IFG));
  end

  // Saturating data byte counter, restarted at each delimiter
  always_ff @(posedge MRxClk or negedge Reset_n) begin
    if (!Reset_n)                 ByteCnt <= '0;
    else if (startData)           ByteCnt <= '0;
    else if (countCycle && !atMax) ByteCnt <= ByteCnt + CNT_W'(1);
  end

  // Per-frame status flags, held from frame end until the next delimiter
  always_ff @(posedge MRxClk or negedge Reset_n) begin
    if (!Reset_n) begin
      flags <= '0;
    end else if (startData) begin
      flags <= '0;
    end else begin
      if (state == ST_DATA0 && MRxDV && !errHit && atMax) flags.oversize <= 1'b1;
      if (inData && MRxDV && errHit)                      flags.rxErr    <= 1'b1;
      if (NIBBLE && state == ST_DATA1 && !MRxDV)          flags.dribble  <= 1'b1;
    end
  end

  // End-of-frame pulse only for frames that left through a data state
  always_ff @(posedge MRxClk or negedge Reset_n) begin
    if (!Reset_n) FrameDone <= 1'b0;
    else          FrameDone <= inData && !MRxDV;
  end

  assign StateIdle     = (state == ST_IDLE);
  assign StatePreamble = (state == ST_PREAMBLE);
  assign StateSFD      = (state == ST_SFD);
  assign StateDrop     = (state == ST_DROP);
  assign StateData     = {NIBBLE && (state == ST_DATA1), state == ST_DATA0};
  assign Oversize      = flags.oversize;
  assign RxErrSeen     = flags.rxErr;
  assign Dribble       = flags.dribble;

endmodule

// File: tb/tb_eth_rxstatem_gen.sv
// tb/tb_eth_rxstatem_gen.sv - scoreboard bench for the MII and GMII receive state machine
module tb_eth_rxstatem_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       dv4, err4, tx4;
  logic [3:0] d4;
  logic       idle4, pre4, sfd4, drop4, done4, ovs4, rxe4, drb4;
  logic [1:0] data4;
  logic [15:0] cnt4;

  logic       dv8, err8, tx8;
  logic [7:0] d8;
  logic       idle8, pre8, sfd8, drop8, done8, ovs8, rxe8, drb8;
  logic [1:0] data8;
  logic [15:0] cnt8;

  eth_rxstatem_gen #(.DATA_W(4)) u4 (
    .MRxClk(clk), .Reset_n(rst_n), .MRxDV(dv4), .MRxD(d4), .MRxErr(err4), .Transmitting(tx4),
    .StateIdle(idle4), .StatePreamble(pre4), .StateSFD(sfd4), .StateDrop(drop4), .StateData(data4),
    .ByteCnt(cnt4), .FrameDone(done4), .Oversize(ovs4), .RxErrSeen(rxe4), .Dribble(drb4)
  );

  eth_rxstatem_gen #(.DATA_W(8), .MAX_FRAME(64)) u8 (
    .MRxClk(clk), .Reset_n(rst_n), .MRxDV(dv8), .MRxD(d8), .MRxErr(err8), .Transmitting(tx8),
    .StateIdle(idle8), .StatePreamble(pre8), .StateSFD(sfd8), .StateDrop(drop8), .StateData(data8),
    .ByteCnt(cnt8), .FrameDone(done8), .Oversize(ovs8), .RxErrSeen(rxe8), .Dribble(drb8)
  );

  typedef struct {
    int cnt;
    bit drb;
    bit ovs;
    bit rxe;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  int   errors = 0;
  int   checks = 0;
  int   bad;

`ifdef ETH_RXSTATEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push4(input int c, input bit d);
    exp_t e;
    e.cnt = c; e.drb = d; e.ovs = 1'b0; e.rxe = 1'b0;
    q4.push_back(e);
  endtask

  task automatic push8(input int c);
    exp_t e;
    e.cnt = c; e.drb = 1'b0; e.ovs = 1'b0; e.rxe = 1'b0;
    q8.push_back(e);
  endtask

  // Monitors: every FrameDone pulse must match the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL w4 unexpected FrameDone: got 1 expected 0");
      end else begin
        e = q4.pop_front();
        chk("w4 ByteCnt", cnt4, e.cnt);
        chk("w4 Dribble", drb4, e.drb);
        chk("w4 Oversize", ovs4, e.ovs);
        chk("w4 RxErrSeen", rxe4, e.rxe);
      end
    end
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL w8 unexpected FrameDone: got 1 expected 0");
      end else begin
        e = q8.pop_front();
        chk("w8 ByteCnt", cnt8, e.cnt);
        chk("w8 Dribble", drb8, e.drb);
        chk("w8 Oversize", ovs8, e.ovs);
        chk("w8 RxErrSeen", rxe8, e.rxe);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle4n(input int n);
    dv4 = 1'b0; d4 = 4'h0; err4 = 1'b0;
    repeat (n) tick();
  endtask

  task automatic idle8n(input int n);
    dv8 = 1'b0; d8 = 8'h00;
    repeat (n) tick();
  endtask

  // Nibble frame: preamble, SFD, data; errAt >= 0 raises MRxErr on that nibble
  task automatic frame4(input int npre, input int ndata, input int errAt, output int altBad);
    altBad = 0;
    dv4 = 1'b1; d4 = 4'h5;
    repeat (npre) tick();
    d4 = 4'hD;
    tick();
    for (int i = 0; i < ndata; i++) begin
      d4   = 4'(i * 3 + 1);
      err4 = (i == errAt);
      if ((errAt < 0 || i <= errAt) && data4 !== ((i % 2 == 0) ? 2'b01 : 2'b10)) altBad++;
      tick();
    end
    err4 = 1'b0;
    dv4  = 1'b0;
    tick();
  endtask

  task automatic frame8(input int npre, input int ndata);
    dv8 = 1'b1; d8 = 8'h55;
    repeat (npre) tick();
    d8 = 8'hD5;
    tick();
    for (int i = 0; i < ndata; i++) begin
      d8 = 8'(i + 8'h20);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dv4 = 1'b0; d4 = 4'h0; err4 = 1'b0; tx4 = 1'b0;
    dv8 = 1'b0; d8 = 8'h00; err8 = 1'b0; tx8 = 1'b0;
    #23;
    chk("reset StateDrop", drop4, 1);
    chk("reset other states", {idle4, pre4, sfd4, data4}, 0);
    chk("reset ByteCnt", cnt4, 0);
    chk("reset FrameDone/flags", {done4, ovs4, rxe4, drb4}, 0);
    chk("reset w8 StateDrop", drop8, 1);
    chk("reset w8 status", {idle8, data8, cnt8, done8, ovs8, drb8}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal 64-byte nibble frame
    idle4n(30);
    push4(64, 1'b0);
    frame4(15, 128, -1, bad);
    chk("w4 data alternation", bad, 0);
    chk("w4 idle after frame", idle4, 1);

    // Short gap: delimiter after only 10 idle cycles is dropped
    idle4n(9);
    dv4 = 1'b1; d4 = 4'h5;
    repeat (5) tick();
    d4 = 4'hD;
    tick();
    chk("short IFG StateDrop", drop4, 1);
    d4 = 4'h3;
    repeat (4) tick();
    chk("short IFG holds DROP", drop4, 1);
    dv4 = 1'b0;
    tick();
    chk("short IFG idle after", idle4, 1);

    // Odd nibble count: dribble
    idle4n(30);
    push4(64, 1'b1);
    frame4(7, 129, -1, bad);
    chk("w4 odd alternation", bad, 0);

    // Local transmit at carrier rise
    idle4n(30);
    tx4 = 1'b1; dv4 = 1'b1; d4 = 4'h5;
    tick();
    chk("transmitting StateDrop", drop4, 1);
    tx4 = 1'b0;
    tick();
    chk("transmitting holds DROP", drop4, 1);
    dv4 = 1'b0;
    tick();
    chk("transmitting idle after", idle4, 1);

    // PHY error on a DATA1 nibble
    idle4n(30);
    if (!ERR_EN) push4(6, 1'b0);
    frame4(7, 12, 5, bad);
    chk("err alternation", bad, 0);
    chk("err RxErrSeen", rxe4, ERR_EN);

    // GMII oversize frame
    idle8n(30);
    frame8(7, 70);
    chk("w8 oversize StateDrop", drop8, 1);
    chk("w8 Oversize flag", ovs8, 1);
    chk("w8 ByteCnt saturated", cnt8, 64);
    chk("w8 StateData bit1", data8[1], 0);
    idle8n(1);
    chk("w8 idle after oversize", idle8, 1);

    // GMII short good frame clears the oversize flag
    idle8n(30);
    push8(10);
    frame8(7, 10);
    chk("w8 StateData in data", data8, 2'b01);
    idle8n(2);

    // Reset in the middle of a frame
    idle4n(30);
    dv4 = 1'b1; d4 = 4'h5;
    repeat (3) tick();
    d4 = 4'hD;
    tick();
    d4 = 4'hA;
    repeat (4) tick();
    chk("pre-reset DATA0", data4, 2'b01);
    chk("pre-reset ByteCnt", cnt4, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset StateDrop", drop4, 1);
    chk("async reset ByteCnt", cnt4, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post-reset holds DROP", drop4, 1);
    dv4 = 1'b0;
    tick();
    chk("post-reset idle", idle4, 1);
    repeat (4) tick();

    chk("w4 expected frames seen", q4.size(), 0);
    chk("w8 expected frames seen", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
